// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect controls, instruction ROM port and IF/ID register outputs.
// master = fetch stage, slave = the surrounding pipeline (hazard unit, MEM, exception logic, ROM).
interface fetch_stage_if #(
  parameter int N = 64
);
  logic         stall_F;
  logic         flush_D;
  logic         PCSrc_M;
  logic [N-1:0] PCBranch_M;
  logic         Exc;
  logic         ERet;
  logic [N-1:0] ERetAddr;
  logic [5:0]   imem_addr;
  logic [31:0]  imem_q;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;

  modport master (
    input  stall_F, flush_D, PCSrc_M, PCBranch_M, Exc, ERet, ERetAddr, imem_q,
    output imem_addr, instr_D, pc_D, valid_D
  );

  modport slave (
    output stall_F, flush_D, PCSrc_M, PCBranch_M, Exc, ERet, ERetAddr, imem_q,
    input  imem_addr, instr_D, pc_D, valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, ROM word addressing and the IF/ID pipeline register.
// Optional macro FETCH_EXC_EN enables exception entry (Exc) and return-from-exception (ERet) redirects.
module fetch_stage #(
  parameter int           N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'('hD8)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);

  logic [N-1:0] pc;
  logic [N-1:0] pc_next;

  // ROM holds 64 words; PC bits above 7 alias back onto it and byte offset bits are ignored.
  assign fif.imem_addr = pc[7:2];

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_next = pc + N'(4);
`ifdef FETCH_EXC_EN
    if (fif.Exc) begin
      pc_next = EXC_VECTOR;
    end else if (fif.ERet) begin
      pc_next = fif.ERetAddr;
    end else
`endif
    if (fif.PCSrc_M) begin
      pc_next = fif.PCBranch_M;
    end else if (fif.stall_F) begin
      pc_next = pc;
    end
  end

`ifndef FETCH_EXC_EN
  // Exception inputs and vector are intentionally dead in this build.
  logic unused_exc;
  assign unused_exc = ^{fif.Exc, fif.ERet, fif.ERetAddr, EXC_VECTOR};
`endif

  // NOTE: clocked state is written with non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID: a redirect without flush_D still captures the current fetch; the hazard unit owns squashing.
  always_ff @(posedge clk) begin
    if (reset) begin
      fif.instr_D <= '0;
      fif.pc_D    <= '0;
      fif.valid_D <= 1'b0;
    end else if (fif.flush_D) begin
      fif.instr_D <= '0;
      fif.pc_D    <= '0;
      fif.valid_D <= 1'b0;
    end else if (!fif.stall_F) begin
      fif.instr_D <= fif.imem_q;
      fif.pc_D    <= pc;
      fif.valid_D <= 1'b1;
    end
  end

endmodule
